// File: rtl/mix_chain_pipe.sv
// Pipelined AND/OR/XOR/rotate mixer, one round per register stage.
// Optional output transfer counter enabled by MIXP_CNT_EN.
module mix_chain_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2
`ifdef MIXP_CNT_EN
    ,
    output logic [15:0]      out_cnt
`endif
);

    function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[WIDTH-1]};
    endfunction

    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  x_q [STAGES];
    logic [WIDTH-1:0]  z_q [STAGES];
    logic [WIDTH-1:0]  r_q [STAGES];
    logic [WIDTH-1:0]  m_q [STAGES];

    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] vin_d;
    logic [WIDTH-1:0]  xu [STAGES];
    logic [WIDTH-1:0]  zu [STAGES];
    logic [WIDTH-1:0]  x_d [STAGES];
    logic [WIDTH-1:0]  z_d [STAGES];
    logic [WIDTH-1:0]  r_d [STAGES];
    logic [WIDTH-1:0]  m_d [STAGES];

    // A stage may advance if it or any stage downstream of it has a hole.
    always_comb begin
        logic acc;
        acc = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc    = acc | ~v_q[i];
            adv[i] = acc;
        end
    end

    always_comb begin
        vin_d[0] = in_valid;
        xu[0]    = a | b | c;
        zu[0]    = a & b & c & ~d;
        r_d[0]   = a ^ b ^ c;
        m_d[0]   = ~d;
        for (int i = 1; i < STAGES; i++) begin
            vin_d[i] = v_q[i-1];
            xu[i]    = x_q[i-1];
            zu[i]    = z_q[i-1];
            r_d[i]   = r_q[i-1];
            m_d[i]   = m_q[i-1];
        end
        for (int i = 0; i < STAGES; i++) begin
            x_d[i] = rotl1(xu[i] ^ zu[i]) ^ (xu[i] & r_d[i]);
            z_d[i] = (xu[i] & zu[i]) | (r_d[i] & m_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                x_q[i] <= '0;
                z_q[i] <= '0;
                r_q[i] <= '0;
                m_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (adv[i]) begin
                    v_q[i] <= vin_d[i];
                    x_q[i] <= x_d[i];
                    z_q[i] <= z_d[i];
                    r_q[i] <= r_d[i];
                    m_q[i] <= m_d[i];
                end
            end
        end
    end

    assign in_ready  = adv[0] & ~rst;
    assign out_valid = v_q[STAGES-1];
    // Bubbles keep stale data, so mask the results when nothing is valid.
    assign y1 = out_valid ? (x_q[STAGES-1] ^ z_q[STAGES-1]) : '0;
    assign y2 = out_valid ? (x_q[STAGES-1] | z_q[STAGES-1]) : '0;

`ifdef MIXP_CNT_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_cnt = cnt_q;
`endif

endmodule
